// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: default sizes and shared entry/forwarding types for the
// decode-to-execute hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int XLEN_DEF         = 32;
    localparam int REG_FILE_LEN_DEF = 32;
    localparam int DEPTH_DEF        = 3;
    localparam int NUM_SRC_DEF      = 2;
    localparam int RA_W_DEF         = $clog2(REG_FILE_LEN_DEF);
    localparam int LAT_W_DEF        = $clog2(DEPTH_DEF + 1);
    localparam int ST_W_DEF         = (DEPTH_DEF > 1) ? $clog2(DEPTH_DEF) : 1;

    typedef struct packed {
        logic                 valid;
        logic [RA_W_DEF-1:0]  dst;
        logic [LAT_W_DEF-1:0] rem;
    } sb_entry_t;

    // Successor of bypass_t: one forwarding decision per source operand.
    typedef struct packed {
        logic                hit;
        logic [ST_W_DEF-1:0] stage;
        logic [XLEN_DEF-1:0] data;
    } fwd_t;

endpackage

// File: rtl/hazard_scoreboard_match.sv
// sb_match: priority match of one source operand against all tracked stages;
// the youngest (lowest-index) producer decides between forward and stall.
module sb_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int RA_W  = RA_W_DEF,
    parameter int LAT_W = LAT_W_DEF,
    parameter int ST_W  = ST_W_DEF
) (
    input  logic                        used_i,
    input  logic [RA_W-1:0]             src_i,
    input  logic [DEPTH-1:0]            valid_i,
    input  logic [DEPTH-1:0][RA_W-1:0]  dst_i,
    input  logic [DEPTH-1:0][LAT_W-1:0] rem_i,
    output logic                        hit_o,
    output logic                        stall_o,
    output logic [ST_W-1:0]             stage_o
);

    always_comb begin
        hit_o   = 1'b0;
        stall_o = 1'b0;
        stage_o = '0;
        if (used_i && src_i != '0)
            // Walk oldest to youngest so the youngest match overwrites.
            for (int i = DEPTH - 1; i >= 0; i--)
                if (valid_i[i] && dst_i[i] == src_i) begin
                    hit_o   = rem_i[i] == '0;
                    stall_o = rem_i[i] != '0;
                    stage_o = (rem_i[i] == '0) ? ST_W'(i) : '0;
                end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks destination and remaining latency of in-flight
// instructions and resolves decode source operands to forward or stall.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int REG_FILE_LEN = REG_FILE_LEN_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int NUM_SRC      = NUM_SRC_DEF,
    parameter int LAT_W        = $clog2(DEPTH + 1),
    localparam int RA_W        = $clog2(REG_FILE_LEN),
    localparam int ST_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          dec_valid,
    input  logic [NUM_SRC-1:0][RA_W-1:0]  dec_src_reg,
    input  logic [NUM_SRC-1:0]            dec_src_used,
    input  logic [RA_W-1:0]               dec_dst_reg,
    input  logic                          dec_we,
    input  logic [LAT_W-1:0]              dec_lat,
    input  logic                          adv,
    input  logic                          flush,
    input  logic [DEPTH-1:0][XLEN-1:0]    stage_data,
    output logic                          stall,
    output logic                          issue,
    output logic [NUM_SRC-1:0]            fwd_hit,
    output logic [NUM_SRC-1:0][ST_W-1:0]  fwd_stage,
    output logic [NUM_SRC-1:0][XLEN-1:0]  fwd_data
);

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][RA_W-1:0]  dst_q, dst_d;
    logic [DEPTH-1:0][LAT_W-1:0] rem_q, rem_d;
    logic [NUM_SRC-1:0]          src_stall;
    logic                        we_eff;

    assign we_eff = dec_we & (dec_dst_reg != '0);
    assign stall  = dec_valid & (|src_stall);
    assign issue  = dec_valid & adv & ~stall;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        sb_match #(
            .DEPTH (DEPTH),
            .RA_W  (RA_W),
            .LAT_W (LAT_W),
            .ST_W  (ST_W)
        ) u_match (
            .used_i  (dec_src_used[s]),
            .src_i   (dec_src_reg[s]),
            .valid_i (valid_q),
            .dst_i   (dst_q),
            .rem_i   (rem_q),
            .hit_o   (fwd_hit[s]),
            .stall_o (src_stall[s]),
            .stage_o (fwd_stage[s])
        );
        assign fwd_data[s] = fwd_hit[s] ? stage_data[fwd_stage[s]] : '0;
    end

    always_comb begin
        valid_d = valid_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        if (flush) begin
            valid_d = '0;
        end else if (adv) begin
            valid_d[0] = issue & we_eff;
            dst_d[0]   = dec_dst_reg;
            rem_d[0]   = dec_lat - LAT_W'(1);
            for (int i = 1; i < DEPTH; i++) begin
                valid_d[i] = valid_q[i-1];
                dst_d[i]   = dst_q[i-1];
                rem_d[i]   = (rem_q[i-1] == '0) ? '0 : rem_q[i-1] - LAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
        end
    end

    a_dec_lat_legal: assert property (@(posedge clk) disable iff (rst)
        dec_valid |-> (dec_lat != '0 && dec_lat <= LAT_W'(DEPTH)));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic checked against
// a stage-position model (a producer is ready once it reaches stage lat-1).
module tb_hazard_scoreboard;

    localparam int D  = 3;
    localparam int NS = 2;
    localparam int XL = 32;
    localparam int RA = 5;
    localparam int LW = 2;
    localparam int SW = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   dec_valid;
    logic [NS-1:0][RA-1:0]  dec_src_reg;
    logic [NS-1:0]          dec_src_used;
    logic [RA-1:0]          dec_dst_reg;
    logic                   dec_we;
    logic [LW-1:0]          dec_lat;
    logic                   adv;
    logic                   flush;
    logic [D-1:0][XL-1:0]   stage_data;
    logic                   stall;
    logic                   issue;
    logic [NS-1:0]          fwd_hit;
    logic [NS-1:0][SW-1:0]  fwd_stage;
    logic [NS-1:0][XL-1:0]  fwd_data;

    int n_cmp = 0;
    int n_err = 0;

    logic          m_v   [D];
    logic [RA-1:0] m_dst [D];
    int            m_lat [D];

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .dec_valid    (dec_valid),
        .dec_src_reg  (dec_src_reg),
        .dec_src_used (dec_src_used),
        .dec_dst_reg  (dec_dst_reg),
        .dec_we       (dec_we),
        .dec_lat      (dec_lat),
        .adv          (adv),
        .flush        (flush),
        .stage_data   (stage_data),
        .stall        (stall),
        .issue        (issue),
        .fwd_hit      (fwd_hit),
        .fwd_stage    (fwd_stage),
        .fwd_data     (fwd_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic dec(input logic v, input logic [RA-1:0] s0, input logic [RA-1:0] s1,
                       input logic [1:0] u, input logic [RA-1:0] d, input logic w,
                       input logic [LW-1:0] l);
        dec_valid       = v;
        dec_src_reg[0]  = s0;
        dec_src_reg[1]  = s1;
        dec_src_used    = u;
        dec_dst_reg     = d;
        dec_we          = w;
        dec_lat         = l;
    endtask

    // Check outputs against the model, advance the model, then cross one clock edge.
    task automatic cycle();
        logic          es, ei;
        logic [NS-1:0] eh;
        logic [SW-1:0] est [NS];
        logic [XL-1:0] ed  [NS];
        #1;
        es = 1'b0;
        for (int s = 0; s < NS; s++) begin
            eh[s] = 1'b0; est[s] = '0; ed[s] = '0;
            if (dec_src_used[s] && dec_src_reg[s] != 0)
                for (int i = 0; i < D; i++)
                    if (m_v[i] && m_dst[i] == dec_src_reg[s]) begin
                        if (i >= m_lat[i] - 1) begin
                            eh[s] = 1'b1; est[s] = SW'(i); ed[s] = stage_data[i];
                        end else es = 1'b1;
                        break;
                    end
        end
        es = es & dec_valid;
        ei = dec_valid & adv & ~es;
        chk("stall", 64'(stall), 64'(es));
        chk("issue", 64'(issue), 64'(ei));
        for (int s = 0; s < NS; s++) begin
            chk($sformatf("hit%0d", s), 64'(fwd_hit[s]), 64'(eh[s]));
            chk($sformatf("stage%0d", s), 64'(fwd_stage[s]), 64'(est[s]));
            chk($sformatf("data%0d", s), 64'(fwd_data[s]), 64'(ed[s]));
        end
        if (rst || flush) begin
            for (int i = 0; i < D; i++) m_v[i] = 1'b0;
        end else if (adv) begin
            for (int i = D - 1; i > 0; i--) begin
                m_v[i] = m_v[i-1]; m_dst[i] = m_dst[i-1]; m_lat[i] = m_lat[i-1];
            end
            m_v[0]   = ei && dec_we && dec_dst_reg != 0;
            m_dst[0] = dec_dst_reg;
            m_lat[0] = int'(dec_lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        dec(1'b0, 0, 0, 2'b00, 0, 1'b0, 2'd1);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin m_v[i] = 1'b0; m_dst[i] = '0; m_lat[i] = 1; end
        rst = 1'b1; adv = 1'b0; flush = 1'b0; stage_data = '0;
        dec(1'b0, 0, 0, 2'b00, 0, 1'b0, 2'd1);
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_issue", 64'(issue), 64'd0);
        chk("rst_hit", 64'(fwd_hit), 64'd0);
        chk("rst_data", 64'(fwd_data), 64'd0);
        adv = 1'b1;

        // ALU back-to-back
        dec(1'b1, 1, 2, 2'b00, 5, 1'b1, 2'd1); cycle();
        dec(1'b1, 5, 3, 2'b01, 0, 1'b0, 2'd1); stage_data[0] = 32'hDEAD; #1;
        chk("alu_stall", 64'(stall), 64'd0);
        chk("alu_hit", 64'(fwd_hit[0]), 64'd1);
        chk("alu_stage", 64'(fwd_stage[0]), 64'd0);
        chk("alu_data", 64'(fwd_data[0]), 64'hDEAD);
        cycle(); idle(3);

        // Load-use: one bubble, then forward from stage 1
        dec(1'b1, 0, 0, 2'b00, 6, 1'b1, 2'd2); cycle();
        dec(1'b1, 6, 0, 2'b01, 0, 1'b0, 2'd1); stage_data[1] = 32'hBEEF; #1;
        chk("ld_stall", 64'(stall), 64'd1);
        chk("ld_issue", 64'(issue), 64'd0);
        cycle();
        chk("ld_stall2", 64'(stall), 64'd0);
        chk("ld_hit", 64'(fwd_hit[0]), 64'd1);
        chk("ld_stage", 64'(fwd_stage[0]), 64'd1);
        chk("ld_data", 64'(fwd_data[0]), 64'hBEEF);
        cycle(); idle(3);

        // Multiple writers: youngest (stage 0) wins, only src1 hits
        dec(1'b1, 0, 0, 2'b00, 7, 1'b1, 2'd1); cycle();
        idle(1);
        dec(1'b1, 0, 0, 2'b00, 7, 1'b1, 2'd1); cycle();
        dec(1'b1, 3, 7, 2'b11, 0, 1'b0, 2'd1); #1;
        chk("mw_hit", 64'(fwd_hit), 64'b10);
        chk("mw_stage", 64'(fwd_stage[1]), 64'd0);
        chk("mw_stall", 64'(stall), 64'd0);
        cycle(); idle(3);

        // x0 is never tracked; unused sources never stall
        dec(1'b1, 0, 0, 2'b00, 0, 1'b1, 2'd1); cycle();
        dec(1'b1, 0, 0, 2'b11, 0, 1'b0, 2'd1); #1;
        chk("x0_hit", 64'(fwd_hit), 64'd0);
        chk("x0_stall", 64'(stall), 64'd0);
        cycle();
        dec(1'b1, 0, 0, 2'b00, 8, 1'b1, 2'd3); cycle();
        dec(1'b1, 8, 8, 2'b00, 0, 1'b0, 2'd1); #1;
        chk("unused_stall", 64'(stall), 64'd0);
        cycle(); idle(3);

        // Flush kills a pending lat-3 producer
        dec(1'b1, 0, 0, 2'b00, 9, 1'b1, 2'd3); cycle();
        flush = 1'b1; idle(1); flush = 1'b0;
        dec(1'b1, 9, 0, 2'b01, 0, 1'b0, 2'd1); #1;
        chk("fl_stall", 64'(stall), 64'd0);
        chk("fl_hit", 64'(fwd_hit[0]), 64'd0);
        cycle(); idle(3);

        // Freeze during a stall, then release
        dec(1'b1, 0, 0, 2'b00, 10, 1'b1, 2'd3); cycle();
        dec(1'b1, 10, 0, 2'b01, 0, 1'b0, 2'd1); cycle();
        adv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("frz_stall", 64'(stall), 64'd1);
            cycle();
        end
        adv = 1'b1;
        chk("frz_stall_rel", 64'(stall), 64'd1);
        cycle();
        chk("frz_hit", 64'(fwd_hit[0]), 64'd1);
        chk("frz_stage", 64'(fwd_stage[0]), 64'd2);
        cycle(); idle(3);

        // Reset mid-stall
        dec(1'b1, 0, 0, 2'b00, 11, 1'b1, 2'd3); cycle();
        dec(1'b1, 11, 0, 2'b01, 0, 1'b0, 2'd1); #1;
        chk("rs_stall_pre", 64'(stall), 64'd1);
        rst = 1'b1; cycle(); rst = 1'b0; adv = 1'b0; #1;
        chk("rs_stall", 64'(stall), 64'd0);
        chk("rs_issue", 64'(issue), 64'd0);
        chk("rs_hit", 64'(fwd_hit), 64'd0);
        chk("rs_stage", 64'(fwd_stage), 64'd0);
        chk("rs_data", 64'(fwd_data), 64'd0);
        cycle();

        // Randomized traffic over a small register set to provoke hazards
        for (int k = 0; k < 600; k++) begin
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 19) == 0);
            adv   = ($urandom_range(0, 4) != 0);
            for (int i = 0; i < D; i++) stage_data[i] = $urandom;
            dec(1'($urandom_range(0, 3) != 0), RA'($urandom_range(0, 7)), RA'($urandom_range(0, 7)),
                2'($urandom), RA'($urandom_range(0, 7)), 1'($urandom), LW'($urandom_range(1, D)));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
